seg7_display_capture: RTL

Recovers hex digits from a multiplexed, active-low 7-segment display bus (segment lines plus one-hot anode strobes), the inverse of the team's hex-to-7-segment encoding. Each strobed digit is filtered for stability, decoded back to a 4-bit nibble and assembled into a NUM_DIGITS-wide frame. The block sits on the board-test path: it snoops the display pins, or a loopback of them, so the bench and on-chip checkers can read back what the display is showing.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_pattern_decoder.sv | 34 +++
 rtl/seg7_display_capture.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low {a..g} patterns for hex digits 0-F,
// the blank and dash patterns, and the decode result type.
package seg7_pkg;

  localparam logic [6:0] SEG7_0 = 7'b0000001;
  localparam logic [6:0] SEG7_1 = 7'b1001111;
  localparam logic [6:0] SEG7_2 = 7'b0010010;
  localparam logic [6:0] SEG7_3 = 7'b0000110;
  localparam logic [6:0] SEG7_4 = 7'b1001100;
  localparam logic [6:0] SEG7_5 = 7'b0100100;
  localparam logic [6:0] SEG7_6 = 7'b0100000;
  localparam logic [6:0] SEG7_7 = 7'b0001111;
  localparam logic [6:0] SEG7_8 = 7'b0000000;
  localparam logic [6:0] SEG7_9 = 7'b0000100;
  localparam logic [6:0] SEG7_A = 7'b0001000;
  localparam logic [6:0] SEG7_B = 7'b1100000;
  localparam logic [6:0] SEG7_C = 7'b0110001;
  localparam logic [6:0] SEG7_D = 7'b1000010;
  localparam logic [6:0] SEG7_E = 7'b0110000;
  localparam logic [6:0] SEG7_F = 7'b0111000;

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;
  localparam logic [6:0] SEG7_DASH  = 7'b1111110;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg7_decode_t;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational inverse of the hex-to-7-segment encoder; unknown patterns
// (dash included) flag err, the all-off pattern flags blank.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0]   seg,
  output seg7_decode_t result
);

  always_comb begin
    result = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
    case (seg)
      SEG7_0:     result.nibble = 4'h0;
      SEG7_1:     result.nibble = 4'h1;
      SEG7_2:     result.nibble = 4'h2;
      SEG7_3:     result.nibble = 4'h3;
      SEG7_4:     result.nibble = 4'h4;
      SEG7_5:     result.nibble = 4'h5;
      SEG7_6:     result.nibble = 4'h6;
      SEG7_7:     result.nibble = 4'h7;
      SEG7_8:     result.nibble = 4'h8;
      SEG7_9:     result.nibble = 4'h9;
      SEG7_A:     result.nibble = 4'hA;
      SEG7_B:     result.nibble = 4'hB;
      SEG7_C:     result.nibble = 4'hC;
      SEG7_D:     result.nibble = 4'hD;
      SEG7_E:     result.nibble = 4'hE;
      SEG7_F:     result.nibble = 4'hF;
      SEG7_BLANK: result.blank  = 1'b1;
      default:    result.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_display_capture.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds the displayed hex frame.
// Optional decimal-point capture is enabled by defining SEG7_CAPTURE_DP_EN.
module seg7_display_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
`ifdef SEG7_CAPTURE_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_mask,
`endif
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    frame_valid
);

  localparam int         IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

`ifdef SEG7_CAPTURE_DP_EN
  localparam int KEY_W = NUM_DIGITS + 8;
`else
  localparam int KEY_W = NUM_DIGITS + 7;
`endif

  logic [6:0]              seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0]   an_s1, an_s2;
  logic [KEY_W-1:0]        key, prev_key;
  logic [7:0]              cnt, cnt_next;
  logic                    latched;
  logic                    eligible, changed, capture, frame_done;
  logic [IDX_W-1:0]        digit_idx;
  seg7_decode_t            decoded;
  logic [4*NUM_DIGITS-1:0] work_value, next_work_value;
  logic [NUM_DIGITS-1:0]   work_blank, next_work_blank;
  logic [NUM_DIGITS-1:0]   work_err, next_work_err;
  logic [NUM_DIGITS-1:0]   seen_mask, next_seen;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

`ifdef SEG7_CAPTURE_DP_EN
  logic                  dp_s1, dp_s2;
  logic [NUM_DIGITS-1:0] work_dp, next_work_dp;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dp_s1 <= 1'b0;
      dp_s2 <= 1'b0;
    end else begin
      dp_s1 <= dp;
      dp_s2 <= dp_s1;
    end
  end

  assign key = {an_s2, seg_s2, dp_s2};
`else
  assign key = {an_s2, seg_s2};
`endif

  assign eligible = $onehot(~an_s2);
  assign changed  = (key != prev_key);

  // Counter saturates at CNT_MAX; the latch keeps a long stable hold to one capture.
  always_comb begin
    cnt_next = cnt;
    if (!eligible || changed) cnt_next = '0;
    else if (cnt < CNT_MAX)   cnt_next = cnt + 8'd1;
  end

  assign capture = eligible && (cnt_next == CNT_MAX) && (changed || !latched);

  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_s2[i]) digit_idx = IDX_W'(i);
  end

  seg7_pattern_decoder u_decoder (
    .seg    (seg_s2),
    .result (decoded)
  );

  always_comb begin
    next_work_value = work_value;
    next_work_blank = work_blank;
    next_work_err   = work_err;
    next_seen       = seen_mask;
    if (capture) begin
      next_work_value[4*digit_idx +: 4] = decoded.nibble;
      next_work_blank[digit_idx]        = decoded.blank;
      next_work_err[digit_idx]          = decoded.err;
      next_seen[digit_idx]              = 1'b1;
    end
  end

`ifdef SEG7_CAPTURE_DP_EN
  always_comb begin
    next_work_dp = work_dp;
    if (capture) next_work_dp[digit_idx] = ~dp_s2;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      work_dp <= '0;
      dp_mask <= '0;
    end else begin
      if (capture)    work_dp <= next_work_dp;
      if (frame_done) dp_mask <= next_work_dp;
    end
  end
`endif

  assign frame_done = capture && (&next_seen);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_key    <= '0;
      cnt         <= '0;
      latched     <= 1'b0;
      work_value  <= '0;
      work_blank  <= '0;
      work_err    <= '0;
      seen_mask   <= '0;
      value       <= '0;
      blank_mask  <= '0;
      err_mask    <= '0;
      frame_valid <= 1'b0;
    end else begin
      prev_key    <= key;
      cnt         <= cnt_next;
      frame_valid <= frame_done;
      if (capture)                    latched <= 1'b1;
      else if (changed || !eligible)  latched <= 1'b0;
      if (capture) begin
        work_value <= next_work_value;
        work_blank <= next_work_blank;
        work_err   <= next_work_err;
      end
      if (frame_done) begin
        value      <= next_work_value;
        blank_mask <= next_work_blank;
        err_mask   <= next_work_err;
        seen_mask  <= '0;
      end else begin
        seen_mask  <= next_seen;
      end
    end
  end

endmodule
